param_sp_ram: RTL
=================

Name: param_sp_ram

Overview:
Parametrised single-port synchronous RAM, the successor to the team's fixed 8x256 single_port_RAM.
- Generalises data width and depth.
- Selectable read-during-write policy and optional output pipeline register.
- Read-valid strobe.
- Hardware clear engine sweeps the array to a known value after reset or on request.

Used as the general scratch/buffer memory primitive in the memory library; behaviourally modelled array, no vendor macros.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- RDW_MODE, 0, read-during-write policy at the same address: 0 = read-first (old data), 1 = write-first (new data).
- OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2 cycles.
- CLEAR_VAL, 0, DATA_W-bit value written to every word by the clear engine.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rd  in  1  read request, sampled on rising clk.
- wr  in  1  write request, sampled on rising clk.
- addr  in  ADDR_W  word address for rd/wr.
- d_in  in  DATA_W  write data.
- clr  in  1  single-cycle pulse; starts a clear sweep.
- d_out  out  DATA_W  read data; holds the last read value between reads.
- d_valid  out  1  one-cycle strobe, aligned with new d_out.
- busy  out  1  high while the clear engine owns the array.

Behaviour:
- Reset: one clock, asynchronous and active-low reset (rst_n), as decided.
  - On rst_n low: d_out=0, d_valid=0, busy=1, pipeline flushed, FSM=CLEAR, clear counter=0.
  - The array itself is not asynchronously reset.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle writes CLEAR_VAL to array[cnt], then cnt+1.
  - On cnt==DEPTH-1 the write is performed and the next state is RUN; busy deasserts in the same cycle RUN is entered.
  - A sweep takes exactly DEPTH cycles from the first clk edge after rst_n release.
  - rd, wr and clr are ignored (dropped, not queued); d_valid stays 0.
- RUN:
  - Normal access.
  - clr=1 sampled -> next state CLEAR with cnt=0, busy=1 from the next cycle.
  - If rd/wr are asserted in the same cycle as clr, they are still executed.
- Write: wr=1 in RUN writes d_in to array[addr] at that edge.
- Read (rd=1 in RUN):
  - OUT_REG=0: d_out updated and d_valid=1 on the edge after rd is sampled (1-cycle latency).
  - OUT_REG=1: the same happens one cycle later (2-cycle latency).
  - Back-to-back reads give one result per cycle.
  - d_valid is low in every cycle without a completing read.
- rd=1 and wr=1 at the same addr in the same cycle:
  - RDW_MODE=0: d_out returns the pre-write contents.
  - RDW_MODE=1: d_out returns d_in.
  - The write always completes.
- Address arithmetic: addr is used modulo DEPTH, no out-of-range state. The clear counter is ADDR_W+1 bits so it terminates cleanly at DEPTH-1.
- Reset mid-operation:
  - Any in-flight read is discarded (no d_valid).
  - Reset mid-clear restarts the sweep from address 0 after release.
- A read already in the OUT_REG pipeline when clr is accepted still completes and pulses d_valid.
- No combinational path from inputs to outputs.

Test Plan:
- Reset release (defaults, DEPTH=256) -> busy=1 for exactly 256 cycles, then 0; rd at addr 0x10 -> d_out=0x00 with d_valid one cycle later.
- wr d_in=0xA5 @0x10, next cycle rd @0x10 -> d_out=0xA5, d_valid high for exactly one cycle; repeat at addr 0xFF with 0x3C, and at 0x00 with 0xC3 -> 0x3C and 0xC3 respectively.
- array[0x20]=0x11, then rd=wr=1 @0x20 with d_in=0x22 -> RDW_MODE=0 gives d_out=0x11; RDW_MODE=1 gives d_out=0x22; subsequent rd gives 0x22 in both builds.
- Fill 0x00..0xFF with random data, pulse clr -> busy high 256 cycles; a wr of 0x77 @0x05 during busy is dropped; afterwards all 256 reads return 0x00 (also CLEAR_VAL=0x5A build -> all 0x5A).
- OUT_REG=1, wr 0x01/0x02/0x03 @0x00..0x02, then rd on three consecutive cycles -> d_out 0x01, 0x02, 0x03 on cycles +2, +3, +4, with d_valid high on those three cycles only.
- Assert rst_n low at clear count 100, release -> busy stays high for a full 256 cycles after release; a read issued just before reset never produces d_valid.

Source files
------------

// File: rtl/param_sp_ram.sv
// Parametrised single-port synchronous RAM.
// It has a selectable read-during-write policy and an optional output register.
// A clear engine sweeps CLEAR_VAL into every word after reset or on a clr pulse.
module param_sp_ram #(
    parameter int                 DATA_W    = 8,
    parameter int                 ADDR_W    = 8,
    parameter int                 RDW_MODE  = 0,
    parameter int                 OUT_REG   = 0,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    input  logic              clr,
    output logic [DATA_W-1:0] d_out,
    output logic              d_valid,
    output logic              busy
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W:0]     cnt, cnt_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                rd_fire;
    logic [DATA_W-1:0]   rd_data;
    logic                src_vld;
    logic [DATA_W-1:0]   src_dat;

    // State and clear-counter register; reset always restarts the sweep at word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state plus array port steering.
    // The clear engine owns the write port in CLEAR, and user requests are dropped there.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_en     = 1'b0;
        wr_addr   = addr;
        wr_data   = d_in;
        rd_fire   = 1'b0;
        case (state)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = cnt[ADDR_W-1:0];
                wr_data = CLEAR_VAL;
                if (cnt == CNT_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + (ADDR_W + 1)'(1);
                end
            end
            default: begin
                wr_en   = wr;
                rd_fire = rd;
                if (clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
        endcase
    end

    // Read and write share one address.
    // Write-first forwards d_in, while read-first sees the old word because the array update is non-blocking.
    assign rd_data = (RDW_MODE != 0 && wr) ? d_in : mem[addr];
    assign busy    = (state == CLEAR);

    // Array storage; deliberately not reset, the clear engine initialises it.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic              p_vld;
            logic [DATA_W-1:0] p_dat;

            // Extra read stage; flushed by reset but untouched by clr so in-flight reads complete.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_vld <= 1'b0;
                    p_dat <= '0;
                end else begin
                    p_vld <= rd_fire;
                    if (rd_fire) p_dat <= rd_data;
                end
            end
            assign src_vld = p_vld;
            assign src_dat = p_dat;
        end else begin : g_noreg
            assign src_vld = rd_fire;
            assign src_dat = rd_data;
        end
    endgenerate

    // Output register: d_out holds the last read value, and d_valid pulses once per completed read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out   <= '0;
            d_valid <= 1'b0;
        end else begin
            d_valid <= src_vld;
            if (src_vld) d_out <= src_dat;
        end
    end

endmodule
